// File: rtl/pipe_stage_chain_if.sv
// Upstream (in_*) and downstream (out_*) valid/ready channels of a pipe_stage_chain.
interface pipe_stage_chain_if #(
    parameter int NBits     = 32,
    parameter int CTRL_BITS = 8
);
    logic                 in_Valid;
    logic [NBits-1:0]     in_Data;
    logic [CTRL_BITS-1:0] in_Ctrl;
    logic                 in_Ready;
    logic                 out_Valid;
    logic [NBits-1:0]     out_Data;
    logic [CTRL_BITS-1:0] out_Ctrl;
    logic                 out_Ready;

    modport master (
        output in_Valid, in_Data, in_Ctrl, out_Ready,
        input  in_Ready, out_Valid, out_Data, out_Ctrl
    );

    modport slave (
        input  in_Valid, in_Data, in_Ctrl, out_Ready,
        output in_Ready, out_Valid, out_Data, out_Ctrl
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline registers (data + ctrl + valid) with global stall, per-stage flush, stats.
// Latency: DEPTH cycles from acceptance to out_Valid when unstalled and unblocked.
// Backpressure: out_Ready=0 holds the tail; bubbles collapse so upstream items keep advancing.
module pipe_stage_chain #(
    parameter int                   NBits     = 32,
    parameter int                   CTRL_BITS = 8,
    parameter int                   DEPTH     = 2,
    parameter logic [CTRL_BITS-1:0] NOP_CTRL  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    pipe_stage_chain_if.slave            bus,
    input  logic                         Stall,
    input  logic [DEPTH-1:0]             Flush,
    output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
    output logic [15:0]                  StallCount,
    output logic [15:0]                  FlushCount
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     validQ;
    logic [NBits-1:0]     dataQ [DEPTH];
    logic [CTRL_BITS-1:0] ctrlQ [DEPTH];
    logic [DEPTH-1:0]     effVld;
    logic [DEPTH-1:0]     adv;
    logic                 inAccept;
    logic [3:0]           killCnt;
    logic [16:0]          flushSum;

    assign effVld = validQ & ~Flush;

    // Walk from the tail back so each stage sees whether its successor frees up.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = effVld[DEPTH-1] & bus.out_Ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = effVld[i] & (~effVld[i+1] | adv[i+1]);
        end
    end

    assign bus.in_Ready  = ~Stall & (~effVld[0] | adv[0]);
    assign bus.out_Valid = effVld[DEPTH-1] & ~Stall;
    assign bus.out_Data  = dataQ[DEPTH-1];
    assign bus.out_Ctrl  = ctrlQ[DEPTH-1];
    assign inAccept      = bus.in_Valid & bus.in_Ready;

    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        logic [NBits-1:0]     srcData;
        logic [CTRL_BITS-1:0] srcCtrl;
        logic                 load;
        logic                 vQ;
        logic [NBits-1:0]     dQ;
        logic [CTRL_BITS-1:0] cQ;

        if (g == 0) begin : gHead
            assign srcData = bus.in_Data;
            assign srcCtrl = bus.in_Ctrl;
            assign load    = inAccept;
        end else begin : gBody
            assign srcData = dataQ[g-1];
            assign srcCtrl = ctrlQ[g-1];
            assign load    = ~Stall & adv[g-1];
        end

        // A load wins over Flush: flush only kills what the stage already holds.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vQ <= 1'b0;
                dQ <= '0;
                cQ <= NOP_CTRL;
            end else if (load) begin
                vQ <= 1'b1;
                dQ <= srcData;
                cQ <= srcCtrl;
            end else if (Flush[g] | (~Stall & adv[g])) begin
                vQ <= 1'b0;
                dQ <= '0;
                cQ <= NOP_CTRL;
            end
        end

        assign validQ[g] = vQ;
        assign dataQ[g]  = dQ;
        assign ctrlQ[g]  = cQ;
    end

    always_comb begin
        Occupancy = '0;
        killCnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            Occupancy = Occupancy + OCC_W'(validQ[i]);
            killCnt   = killCnt + 4'(validQ[i] & Flush[i]);
        end
    end

    assign flushSum = {1'b0, FlushCount} + 17'(killCnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (Stall && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end
            FlushCount <= flushSum[16] ? 16'hFFFF : flushSum[15:0];
        end
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed tests of pipe_stage_chain at DEPTH=3: streaming, backpressure, collapse, stall, flush, reset.
module tb_pipe_stage_chain;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             Stall;
    logic [DEPTH-1:0] Flush;
    logic [1:0]       Occupancy;
    logic [15:0]      StallCount;
    logic [15:0]      FlushCount;
    int               checks = 0;
    int               passed = 0;

    pipe_stage_chain_if #(.NBits(32), .CTRL_BITS(8)) bus ();

    pipe_stage_chain #(
        .NBits(32), .CTRL_BITS(8), .DEPTH(DEPTH), .NOP_CTRL(8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .Stall      (Stall),
        .Flush      (Flush),
        .Occupancy  (Occupancy),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl(input logic [31:0] d);
        return d[7:0] ^ 8'h80;
    endfunction

    task automatic setIn(input logic v, input logic [31:0] d, input logic rdy);
        bus.in_Valid  = v;
        bus.in_Data   = d;
        bus.in_Ctrl   = ctl(d);
        bus.out_Ready = rdy;
    endtask

    task automatic test_reset();
        reset = 1'b0; Stall = 1'b0; Flush = '0;
        setIn(1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.out_Valid !== 1'b0) $display("FAIL reset_outValid got %b want 0", bus.out_Valid); else passed++;
        checks++; if (Occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", Occupancy); else passed++;
        checks++; if (bus.out_Ctrl !== 8'h00) $display("FAIL reset_outCtrl got %h want 00", bus.out_Ctrl); else passed++;
        checks++; if (bus.out_Data !== 32'h0) $display("FAIL reset_outData got %h want 0", bus.out_Data); else passed++;
        checks++; if (StallCount !== 16'd0) $display("FAIL reset_stallCnt got %0d want 0", StallCount); else passed++;
        checks++; if (FlushCount !== 16'd0) $display("FAIL reset_flushCnt got %0d want 0", FlushCount); else passed++;
        checks++; if (bus.in_Ready !== 1'b1) $display("FAIL reset_inReady got %b want 1", bus.in_Ready); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] pushD [6] = '{32'h1111, 32'h2222, 32'h3333, 32'h0, 32'h0, 32'h0};
        logic        pushV [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          expOcc [6] = '{0, 1, 2, 3, 2, 1};
        logic        expV [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] expD [6] = '{32'h0, 32'h0, 32'h0, 32'h1111, 32'h2222, 32'h3333};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            setIn(pushV[k], pushD[k], 1'b1);
            #1;
            checks++; if (bus.out_Valid !== expV[k]) $display("FAIL stream_outValid[%0d] got %b want %b", k, bus.out_Valid, expV[k]); else passed++;
            checks++; if (Occupancy !== 2'(expOcc[k])) $display("FAIL stream_occ[%0d] got %0d want %0d", k, Occupancy, expOcc[k]); else passed++;
            if (expV[k]) begin
                checks++; if (bus.out_Data !== expD[k]) $display("FAIL stream_outData[%0d] got %h want %h", k, bus.out_Data, expD[k]); else passed++;
                checks++; if (bus.out_Ctrl !== ctl(expD[k])) $display("FAIL stream_outCtrl[%0d] got %h want %h", k, bus.out_Ctrl, ctl(expD[k])); else passed++;
            end
        end
        @(negedge clk);
        setIn(1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (bus.out_Valid !== 1'b0) $display("FAIL stream_drained_vld got %b want 0", bus.out_Valid); else passed++;
        checks++; if (Occupancy !== 2'd0) $display("FAIL stream_drained_occ got %0d want 0", Occupancy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] items [4] = '{32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIn(1'b1, items[k], 1'b0);
            #1;
            checks++; if (bus.in_Ready !== 1'b1) $display("FAIL bp_fill_inReady[%0d] got %b want 1", k, bus.in_Ready); else passed++;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            setIn(1'b1, items[3], 1'b0);
            #1;
            checks++; if (bus.in_Ready !== 1'b0) $display("FAIL bp_hold_inReady[%0d] got %b want 0", k, bus.in_Ready); else passed++;
            checks++; if (bus.out_Data !== items[0]) $display("FAIL bp_hold_outData[%0d] got %h want %h", k, bus.out_Data, items[0]); else passed++;
            checks++; if (Occupancy !== 2'd3) $display("FAIL bp_hold_occ[%0d] got %0d want 3", k, Occupancy); else passed++;
        end
        @(negedge clk);
        setIn(1'b1, items[3], 1'b1);
        #1;
        checks++; if (bus.in_Ready !== 1'b1) $display("FAIL bp_release_inReady got %b want 1", bus.in_Ready); else passed++;
        checks++; if (bus.out_Valid !== 1'b1) $display("FAIL bp_release_outValid got %b want 1", bus.out_Valid); else passed++;
        @(negedge clk);
        setIn(1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.out_Data !== items[1]) $display("FAIL bp_after_outData got %h want %h", bus.out_Data, items[1]); else passed++;
        checks++; if (Occupancy !== 2'd3) $display("FAIL bp_after_occ got %0d want 3", Occupancy); else passed++;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            setIn(1'b0, 32'h0, 1'b1);
            #1;
            checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[k]) $display("FAIL bp_drain[%0d] got %b/%h want 1/%h", k, bus.out_Valid, bus.out_Data, items[k]); else passed++;
        end
        @(negedge clk);
        #1;
        checks++; if (Occupancy !== 2'd0) $display("FAIL bp_empty_occ got %0d want 0", Occupancy); else passed++;
    endtask

    task automatic test_bubble_collapse();
        logic [31:0] items [3] = '{32'h5100_0001, 32'h5200_0002, 32'h5300_0003};
        @(negedge clk); setIn(1'b1, items[0], 1'b0);
        @(negedge clk); setIn(1'b0, 32'h0, 1'b0);
        @(negedge clk); setIn(1'b1, items[1], 1'b0);
        #1;
        checks++; if (Occupancy !== 2'd1) $display("FAIL bub_occ1 got %0d want 1", Occupancy); else passed++;
        @(negedge clk); setIn(1'b1, items[2], 1'b0);
        #1;
        checks++; if (Occupancy !== 2'd2) $display("FAIL bub_occ2 got %0d want 2", Occupancy); else passed++;
        checks++; if (bus.in_Ready !== 1'b1) $display("FAIL bub_inReady got %b want 1", bus.in_Ready); else passed++;
        @(negedge clk); setIn(1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (Occupancy !== 2'd3) $display("FAIL bub_occ3 got %0d want 3", Occupancy); else passed++;
        checks++; if (bus.in_Ready !== 1'b0) $display("FAIL bub_full_inReady got %b want 0", bus.in_Ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIn(1'b0, 32'h0, 1'b1);
            #1;
            checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[k]) $display("FAIL bub_drain[%0d] got %b/%h want 1/%h", k, bus.out_Valid, bus.out_Data, items[k]); else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] items [4] = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIn(1'b1, items[k], 1'b1);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            Stall = 1'b1;
            setIn(1'b1, items[3], 1'b1);
            #1;
            checks++; if (bus.in_Ready !== 1'b0) $display("FAIL stall_inReady[%0d] got %b want 0", j, bus.in_Ready); else passed++;
            checks++; if (bus.out_Valid !== 1'b0) $display("FAIL stall_outValid[%0d] got %b want 0", j, bus.out_Valid); else passed++;
            checks++; if (Occupancy !== 2'd3 || bus.out_Data !== items[0]) $display("FAIL stall_hold[%0d] got %0d/%h want 3/%h", j, Occupancy, bus.out_Data, items[0]); else passed++;
            checks++; if (StallCount !== 16'(j)) $display("FAIL stall_count[%0d] got %0d want %0d", j, StallCount, j); else passed++;
        end
        @(negedge clk);
        Stall = 1'b0;
        setIn(1'b1, items[3], 1'b1);
        #1;
        checks++; if (StallCount !== 16'd4) $display("FAIL stall_count_final got %0d want 4", StallCount); else passed++;
        checks++; if (bus.in_Ready !== 1'b1) $display("FAIL stall_resume_inReady got %b want 1", bus.in_Ready); else passed++;
        checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[0]) $display("FAIL stall_resume_out got %b/%h want 1/%h", bus.out_Valid, bus.out_Data, items[0]); else passed++;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            setIn(1'b0, 32'h0, 1'b1);
            #1;
            checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[k]) $display("FAIL stall_drain[%0d] got %b/%h want 1/%h", k, bus.out_Valid, bus.out_Data, items[k]); else passed++;
        end
        @(negedge clk);
        #1;
        checks++; if (bus.out_Valid !== 1'b0) $display("FAIL stall_empty got %b want 0", bus.out_Valid); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] items [4] = '{32'hF000_000A, 32'hF000_000B, 32'hF000_000C, 32'hF000_000D};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIn(1'b1, items[k], 1'b0);
        end
        @(negedge clk);
        Flush = 3'b011;
        setIn(1'b1, items[3], 1'b1);
        #1;
        checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[0]) $display("FAIL flush_deliverA got %b/%h want 1/%h", bus.out_Valid, bus.out_Data, items[0]); else passed++;
        checks++; if (bus.in_Ready !== 1'b1) $display("FAIL flush_inReady got %b want 1", bus.in_Ready); else passed++;
        checks++; if (FlushCount !== 16'd0) $display("FAIL flush_count_pre got %0d want 0", FlushCount); else passed++;
        @(negedge clk);
        Flush = 3'b000;
        setIn(1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (FlushCount !== 16'd2) $display("FAIL flush_count got %0d want 2", FlushCount); else passed++;
        checks++; if (Occupancy !== 2'd1) $display("FAIL flush_occ got %0d want 1", Occupancy); else passed++;
        checks++; if (bus.out_Valid !== 1'b0) $display("FAIL flush_outValid got %b want 0", bus.out_Valid); else passed++;
        @(negedge clk);
        #1;
        checks++; if (Occupancy !== 2'd1 || bus.out_Valid !== 1'b0) $display("FAIL flush_moveD got %0d/%b want 1/0", Occupancy, bus.out_Valid); else passed++;
        @(negedge clk);
        #1;
        checks++; if (bus.out_Valid !== 1'b1 || bus.out_Data !== items[3]) $display("FAIL flush_outD got %b/%h want 1/%h", bus.out_Valid, bus.out_Data, items[3]); else passed++;
        checks++; if (bus.out_Ctrl !== ctl(items[3])) $display("FAIL flush_outCtrlD got %h want %h", bus.out_Ctrl, ctl(items[3])); else passed++;
        @(negedge clk);
        Flush = 3'b111;
        #1;
        checks++; if (Occupancy !== 2'd0) $display("FAIL flush_empty_occ got %0d want 0", Occupancy); else passed++;
        @(negedge clk);
        Flush = 3'b000;
        #1;
        checks++; if (FlushCount !== 16'd2) $display("FAIL flush_empty_count got %0d want 2", FlushCount); else passed++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setIn(1'b1, 32'hE000_0011 + 32'(k), 1'b0);
        end
        @(negedge clk);
        setIn(1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (Occupancy !== 2'd3 || bus.out_Valid !== 1'b1) $display("FAIL arst_pre got %0d/%b want 3/1", Occupancy, bus.out_Valid); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.out_Valid !== 1'b0) $display("FAIL arst_outValid got %b want 0", bus.out_Valid); else passed++;
        checks++; if (Occupancy !== 2'd0) $display("FAIL arst_occ got %0d want 0", Occupancy); else passed++;
        checks++; if (bus.out_Ctrl !== 8'h00) $display("FAIL arst_outCtrl got %h want 00", bus.out_Ctrl); else passed++;
        checks++; if (bus.out_Data !== 32'h0) $display("FAIL arst_outData got %h want 0", bus.out_Data); else passed++;
        checks++; if (StallCount !== 16'd0 || FlushCount !== 16'd0) $display("FAIL arst_counters got %0d/%0d want 0/0", StallCount, FlushCount); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_stall();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t without completing", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (IF/ID, EX/MEM) in the MIPS core.
- Implements a chain of DEPTH pipeline stages, each carrying a data bundle and a control bundle plus a valid bit.
- Supports global stall (hazard-unit hold), per-stage flush (branch/jump kill), downstream backpressure with bubble collapse, and occupancy/stall/flush statistics.
- Sits between pipeline stages of the processor wherever a stage register is needed.

Parameters:
- NBits, 32, width of the data bundle.
- CTRL_BITS, 8, width of the control bundle.
- DEPTH, 2, number of register stages; legal range 1..8.
- NOP_CTRL, 0, control value loaded into any stage holding a bubble.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_Valid  input  1  upstream item present.
- in_Data  input  NBits  upstream data.
- in_Ctrl  input  CTRL_BITS  upstream control.
- in_Ready  output  1  chain accepts an item this cycle.
- Stall  input  1  freeze all stages.
- Flush  input  DEPTH  per-stage kill; bit i targets stage i (stage 0 is nearest the input).
- out_Valid  output  1  last stage holds a live item.
- out_Data  output  NBits  last-stage data.
- out_Ctrl  output  CTRL_BITS  last-stage control.
- out_Ready  input  1  downstream accepts.
- Occupancy  output  $clog2(DEPTH+1)  number of valid stages.
- StallCount  output  16  cycles with Stall=1, saturating.
- FlushCount  output  16  valid items killed by Flush, saturating.

Behaviour:
- Reset (async, reset=0) clears every stage: valid=0, data=0, ctrl=NOP_CTRL. Occupancy, StallCount and FlushCount are all 0.
- Effective valid per stage: ev[i] = valid[i] & ~Flush[i]. A flushed item is never transferred.
- Advance (all combinational):
  - adv[D-1] = ev[D-1] & out_Ready.
  - adv[i] = ev[i] & (~ev[i+1] | adv[i+1]).
  - free[i] = ~ev[i] | adv[i].
- Outputs:
  - in_Ready = ~Stall & free[0].
  - out_Valid = ev[D-1] & ~Stall.
  - out_Data and out_Ctrl always show the last-stage registers.
  - A downstream transfer occurs when out_Valid & out_Ready.
- Stall=1:
  - No stage loads or advances.
  - Stages with Flush[i]=1 become bubbles in place (valid=0, data=0, ctrl=NOP_CTRL).
  - All other stages hold.
- Stall=0, at each edge:
  - Stage i (i>0) loads stage i-1 if adv[i-1].
  - Otherwise, if adv[i] or Flush[i], it becomes a bubble; otherwise it holds.
  - Stage 0 loads the input if in_Valid & in_Ready.
  - Otherwise, if adv[0] or Flush[0], it becomes a bubble; otherwise it holds.
- Flush[i] and a load into stage i in the same cycle: the incoming item is kept. Flush kills the current content only.
- Bubble collapse: a bubble in stage i lets upstream items advance even when out_Ready=0.
- Latency: an item accepted at edge N is visible on out after edge N+DEPTH-1, i.e. DEPTH cycles with no stalls or backpressure.
- With DEPTH=1, the chain reduces to one register with the same rules.
- Occupancy = popcount(valid), registered values, unmasked by Flush.
- StallCount increments each edge with Stall=1 and saturates at 16'hFFFF.
- FlushCount adds popcount(valid & Flush) each edge and saturates at 16'hFFFF.
- Data ordering is preserved. No item is duplicated or lost except by Flush.

Test Plan:
(All scenarios use DEPTH=3, NBits=32, CTRL_BITS=8, NOP_CTRL=8'h00.)
- Streaming: push 32'h1111,32'h2222,32'h3333 on consecutive cycles with out_Ready=1. Required: out_Valid rises 3 cycles after the first push, then the values appear in order, one per cycle. Occupancy reaches 3.
- Backpressure: fill with A,B,C; hold out_Ready=0. Required: in_Ready=0 and out_Data=A held. Release out_Ready for 1 cycle: A transfers, in_Ready=1 the same cycle.
- Bubble collapse: stage1 empty, stages 0 and 2 valid, out_Ready=0. Required: after 1 edge, stage1 holds the former stage-0 item, stage0 accepts a new input, and Occupancy=3.
- Stall: assert Stall for 4 cycles mid-stream with in_Valid=1. Required: in_Ready=0, out_Valid=0, contents unchanged, StallCount=4, and the stream resumes in order.
- Flush: with A,B,C in stages 2,1,0, pulse Flush=3'b011 with out_Ready=1. Required: A is delivered, B and C are discarded, FlushCount=2, and the new input D still loads into stage 0.
- Async reset mid-operation: drop reset to 0 between clock edges while full. Required: out_Valid=0, Occupancy=0, out_Ctrl=8'h00 and counters=0 immediately, without waiting for a clock edge.
